// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default sizes for the UART receive path.
// The receiver and uart_rx_fifo both take their byte width from UART_DATA_W.
package uart_pkg;

   localparam int unsigned UART_DATA_W     = 8;
   localparam int unsigned UART_FIFO_DEPTH = 16;

   // Capture FSM: WAIT for a completed byte, ACK it until the receiver drops done
   typedef enum logic {
      ST_WAIT = 1'b0,
      ST_ACK  = 1'b1
   } cap_state_e;

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x DATA_W storage, synchronous write, asynchronous read.
// Contents are deliberately not reset.
module uart_fifo_ram #(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Write port: one entry per clock when enabled
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read port: combinational so the FIFO head falls through
   assign o_rdata = r_mem[i_raddr];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures bytes from the UART receiver (data/done), acks them on
// rx_clear and queues them in a first-word-fall-through FIFO with a
// valid/ready output stream.
// Build option UART_RX_FIFO_OVF_EN: when defined, a byte arriving at a full
// queue is acked and dropped and the sticky overflow flag is set; when
// undefined, the ack is withheld so the receiver holds the byte (lossless).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH  = UART_FIFO_DEPTH,
   parameter int unsigned DATA_W = UART_DATA_W,
   parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_done,
   output logic              rx_clear,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [PTR_W:0]    count,
   output logic              overflow,
   input  logic              ovf_clr
);

   localparam logic [PTR_W:0] LP_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] LP_ONE  = (PTR_W+1)'(1);

   cap_state_e        r_state;
   cap_state_e        w_state_nxt;
   logic              r_rx_clear;
   logic              r_m_valid;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic [PTR_W:0]    w_count_nxt;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_space;
`ifdef UART_RX_FIFO_OVF_EN
   logic              w_drop;
   logic              r_overflow;
`else
   logic              w_unused_ovf_clr;
`endif

   assign w_pop   = r_m_valid && m_ready;
   assign w_full  = (r_count == LP_FULL);
   // A pop on the same edge frees the slot the new byte needs
   assign w_space = !w_full || w_pop;

   // Capture FSM next-state and push/drop decode
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
`ifdef UART_RX_FIFO_OVF_EN
      w_drop      = 1'b0;
`endif
      case (r_state)
         ST_WAIT: begin
            if (rx_done) begin
               if (w_space) begin
                  w_push      = 1'b1;
                  w_state_nxt = ST_ACK;
               end
`ifdef UART_RX_FIFO_OVF_EN
               else begin
                  // Drop-newest: still ack so the receiver never stalls
                  w_drop      = 1'b1;
                  w_state_nxt = ST_ACK;
               end
`endif
            end
         end
         ST_ACK: begin
            // Hold the ack until done falls so a byte is written only once
            if (!rx_done) begin
               w_state_nxt = ST_WAIT;
            end
         end
         default: begin
            w_state_nxt = ST_WAIT;
         end
      endcase
   end

   // Capture FSM state register and registered ack to the receiver
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_WAIT;
         r_rx_clear <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rx_clear <= (w_state_nxt == ST_ACK);
      end
   end

   // Occupancy next value; push and pop together leave it unchanged
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + LP_ONE;
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - LP_ONE;
      end
   end

   // Pointers wrap naturally at DEPTH; count and valid are registered
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_m_valid <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count   <= w_count_nxt;
         r_m_valid <= (w_count_nxt != '0);
      end
   end

`ifdef UART_RX_FIFO_OVF_EN
   // Sticky overflow flag; a drop wins over a simultaneous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   assign overflow = r_overflow;
`else
   assign overflow         = 1'b0;
   assign w_unused_ovf_clr = ovf_clr;
`endif

   uart_fifo_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (rx_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rd_data)
   );

   assign rx_clear = r_rx_clear;
   assign m_valid  = r_m_valid;
   assign count    = r_count;
   // Head reads as zero while the queue is empty
   assign m_data   = r_m_valid ? w_rd_data : '0;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scenarios plus randomized traffic for uart_rx_fifo,
// checked every cycle against a queue-based model of the buffer and a small
// model of the receiver's done/clear handshake.
// Honors UART_RX_FIFO_OVF_EN to match the DUT build.
module tb_uart_rx_fifo;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned PTR_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] rx_data;
   logic              rx_done;
   logic              rx_clear;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic [PTR_W:0]    count;
   logic              overflow;
   logic              ovf_clr;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .PTR_W  (PTR_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_data  (rx_data),
      .rx_done  (rx_done),
      .rx_clear (rx_clear),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .count    (count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] q[$];        // expected queue contents, head at index 0
   bit         pending;     // receiver holds a byte not yet taken by the buffer
   bit         exp_ovf;
   int         clr_seen;    // consecutive sampled cycles with rx_clear high
   int         low_cnt;     // consecutive edges that saw rx_done low

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      chk("count", 32'(count), 32'(q.size()));
      chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
      chk("m_data", 32'(m_data), (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (pending) chk("clr_early", 32'(rx_clear), 32'd0);
   endtask

   // Predict the coming edge, advance one cycle, model the receiver, compare.
   task automatic step();
      bit pop;
      bit full;
      bit drop;
      bit done_at_edge;
      pop  = (q.size() != 0) && m_ready;
      full = (q.size() == DEPTH);
      drop = 1'b0;
      if (pending && rx_done) begin
         if (!full || pop) begin
            if (pop) void'(q.pop_front());
            pop = 1'b0;
            q.push_back(rx_data);
            pending = 1'b0;
         end else begin
`ifdef UART_RX_FIFO_OVF_EN
            drop    = 1'b1;
            pending = 1'b0;
`endif
         end
      end
      if (pop) void'(q.pop_front());
      if (drop) exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
      done_at_edge = rx_done;
      @(posedge clk);
      @(negedge clk);
      low_cnt = done_at_edge ? 0 : low_cnt + 1;
      // Receiver drops done one cycle after it sees clear
      if (rx_clear) begin
         clr_seen++;
         if (clr_seen == 2) rx_done = 1'b0;
      end else if (clr_seen > 0) begin
         chk("clr_len", 32'(clr_seen), 32'd2);
         clr_seen = 0;
      end
      compare_outputs();
   endtask

   task automatic send(input logic [7:0] b);
      int guard;
      guard = 0;
      while (rx_done || low_cnt < 1) begin
         step();
         guard++;
         if (guard > 100) begin
            chk("send_timeout", 32'd1, 32'd0);
            return;
         end
      end
      rx_data = b;
      rx_done = 1'b1;
      pending = 1'b1;
   endtask

   task automatic wait_taken();
      int guard;
      guard = 0;
      while (pending) begin
         step();
         guard++;
         if (guard > 100) begin
            chk("take_timeout", 32'd1, 32'd0);
            return;
         end
      end
   endtask

   task automatic drain();
      m_ready = 1'b1;
      repeat (DEPTH + 6) step();
      m_ready = 1'b0;
      chk("drained", 32'(count), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_clr", 32'(rx_clear), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      q.delete();
      exp_ovf  = 1'b0;
      clr_seen = 0;
      pending  = rx_done;
      @(negedge clk);
      rst     = 1'b0;
      low_cnt = rx_done ? 0 : 1;
   endtask

   initial begin
      rst      = 1'b1;
      rx_data  = '0;
      rx_done  = 1'b0;
      m_ready  = 1'b0;
      ovf_clr  = 1'b0;
      pending  = 1'b0;
      exp_ovf  = 1'b0;
      clr_seen = 0;
      low_cnt  = 0;

      // Reset state
      @(negedge clk);
      chk("init_clr", 32'(rx_clear), 32'd0);
      chk("init_count", 32'(count), 32'd0);
      chk("init_valid", 32'(m_valid), 32'd0);
      chk("init_data", 32'(m_data), 32'd0);
      chk("init_ovf", 32'(overflow), 32'd0);
      rst     = 1'b0;
      low_cnt = 1;

      // Single byte
      send(8'hA5);
      step();
      chk("t1_clr_a", 32'(rx_clear), 32'd1);
      chk("t1_data", 32'(m_data), 32'hA5);
      step();
      chk("t1_clr_b", 32'(rx_clear), 32'd1);
      step();
      chk("t1_clr_c", 32'(rx_clear), 32'd0);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("t1_empty_cnt", 32'(count), 32'd0);
      chk("t1_empty_data", 32'(m_data), 32'd0);

      // Fill to DEPTH with no consumer
      for (int i = 0; i < DEPTH; i++) begin
         send(8'(i));
         wait_taken();
      end
      repeat (3) step();
      chk("fill_count", 32'(count), 32'd16);
      chk("fill_head", 32'(m_data), 32'h00);

      // 17th byte against a full queue
      send(8'h55);
      repeat (6) step();
`ifdef UART_RX_FIFO_OVF_EN
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd16);
      chk("ovf_head", 32'(m_data), 32'h00);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);
`else
      chk("bp_clr", 32'(rx_clear), 32'd0);
      chk("bp_held", 32'(rx_done), 32'd1);
      chk("bp_count", 32'(count), 32'd16);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("bp_count2", 32'(count), 32'd16);
      chk("bp_head", 32'(m_data), 32'h01);
      chk("bp_clr2", 32'(rx_clear), 32'd1);
`endif
      drain();

      // Simultaneous push and pop at count 8
      for (int i = 0; i < 8; i++) begin
         send(8'($urandom));
         wait_taken();
      end
      send(8'h3C);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("pp_count", 32'(count), 32'd8);
      repeat (20) begin
         m_ready = (count > 1);
         step();
      end
      m_ready = 1'b0;
      chk("pp_tail_cnt", 32'(count), 32'd1);
      chk("pp_tail", 32'(m_data), 32'h3C);
      drain();

      // Reset while acking; the held byte is captured again
      send(8'h77);
      step();
      chk("ra_clr", 32'(rx_clear), 32'd1);
      do_reset();
      step();
      chk("ra_count", 32'(count), 32'd1);
      chk("ra_data", 32'(m_data), 32'h77);
      repeat (4) step();
      drain();

      // Randomized traffic: light consumer first so the queue fills, then heavy
      for (int c = 0; c < 3000; c++) begin
         m_ready = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         ovf_clr = ($urandom_range(0, 15) == 0);
         if (!rx_done && low_cnt >= 1 && $urandom_range(0, 1) == 0) begin
            rx_data = 8'($urandom);
            rx_done = 1'b1;
            pending = 1'b1;
         end
         step();
      end
      ovf_clr = 1'b0;
      m_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_uart_rx_fifo
